// File: rtl/kf_sample_sequencer.sv
// kf_sample_sequencer
//   Upstream sequencer for State_equation. Takes one plant sample (U,Y) per
//   input handshake, holds it on U_out/Y_out for one full filter iteration,
//   pulses Start_Prediction then Start_Update, and returns the updated
//   estimate on an output handshake. A one-entry buffer lets the next sample
//   arrive while an iteration is in flight.
//   Optional watchdog: define KF_SEQ_WATCHDOG_EN to abort stuck WAIT_P/WAIT_U
//   states after TIMEOUT enabled cycles (sticky timeout_err).
//
//   Handshake semantics (both sides): a transfer happens on a rising clk edge
//   with clk_en=1 where valid and ready are both 1. The producer holds valid
//   and data stable until that transfer; valid never depends on ready.
module kf_sample_sequencer #(
  parameter int WIDTH   = 16,
  parameter int nos     = 4,
  parameter int noo     = 2,
  parameter int noi     = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH*noi-1:0]   U_in,
  input  logic [WIDTH*noo-1:0]   Y_in,
  output logic [WIDTH*noi-1:0]   U_out,
  output logic [WIDTH*noo-1:0]   Y_out,
  output logic                   Start_Prediction,
  output logic                   Start_Update,
  input  logic                   ready_Prediction,
  input  logic                   ready_Update,
  input  logic [WIDTH*nos-1:0]   X_nkU_in,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH*nos-1:0]   X_out,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [2:0]             dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRED   = 3'd1,
    WAIT_P = 3'd2,
    UPD    = 3'd3,
    WAIT_U = 3'd4,
    SETTLE = 3'd5,
    OUT    = 3'd6
  } state_t;

  state_t                 state_q;
  logic                   buf_full_q;
  logic [WIDTH*noi-1:0]   buf_u_q;
  logic [WIDTH*noo-1:0]   buf_y_q;
  logic [WIDTH*noi-1:0]   u_out_q;
  logic [WIDTH*noo-1:0]   y_out_q;
  logic [WIDTH*nos-1:0]   x_out_q;
  logic                   start_p_q;
  logic                   start_u_q;
  logic                   m_valid_q;
  logic                   busy_q;
  logic                   wait_first_q;
  logic                   timeout_q;
  logic                   accept;
  logic                   consume;
  logic                   wd_expired;

  // Buffer is empty <=> a new sample can be taken.
  assign s_ready = ~buf_full_q;
  assign accept  = clk_en & s_valid & ~buf_full_q;
  // The FSM pulls the buffer only from IDLE, or from OUT when the result leaves.
  assign consume = clk_en & buf_full_q &
                   ((state_q == IDLE) | ((state_q == OUT) & m_ready));

`ifdef KF_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_cnt_q;

  // Watchdog: counts enabled cycles spent in a wait state, zero elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
    end else if (clk_en) begin
      if ((state_q == WAIT_P) || (state_q == WAIT_U)) wd_cnt_q <= wd_cnt_q + 1'b1;
      else                                             wd_cnt_q <= '0;
    end
  end

  assign wd_expired = (wd_cnt_q == WD_LAST);
`else
  assign wd_expired = 1'b0;
`endif

  // One-entry input buffer; accept and consume cannot coincide since accept needs it empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_full_q <= 1'b0;
      buf_u_q    <= '0;
      buf_y_q    <= '0;
    end else if (clk_en) begin
      if (accept) begin
        buf_full_q <= 1'b1;
        buf_u_q    <= U_in;
        buf_y_q    <= Y_in;
      end else if (consume) begin
        buf_full_q <= 1'b0;
      end
    end
  end

  // Iteration FSM with registered strobes and output data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      u_out_q      <= '0;
      y_out_q      <= '0;
      x_out_q      <= '0;
      start_p_q    <= 1'b0;
      start_u_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      wait_first_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else if (clk_en) begin
      start_p_q <= 1'b0;
      start_u_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (buf_full_q) begin
            u_out_q   <= buf_u_q;
            y_out_q   <= buf_y_q;
            start_p_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= PRED;
          end
        end
        PRED: begin
          wait_first_q <= 1'b1;
          state_q      <= WAIT_P;
        end
        WAIT_P: begin
          // First wait cycle still sees the level from the previous iteration.
          wait_first_q <= 1'b0;
          if (!wait_first_q && ready_Prediction) begin
            start_u_q <= 1'b1;
            state_q   <= UPD;
          end else if (wd_expired) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        UPD: begin
          wait_first_q <= 1'b1;
          state_q      <= WAIT_U;
        end
        WAIT_U: begin
          wait_first_q <= 1'b0;
          if (!wait_first_q && ready_Update) begin
            state_q <= SETTLE;
          end else if (wd_expired) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        SETTLE: begin
          // Estimate lands one cycle after ready_Update, so capture here.
          x_out_q   <= X_nkU_in;
          m_valid_q <= 1'b1;
          state_q   <= OUT;
        end
        OUT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            if (buf_full_q) begin
              u_out_q   <= buf_u_q;
              y_out_q   <= buf_y_q;
              start_p_q <= 1'b1;
              state_q   <= PRED;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign U_out            = u_out_q;
  assign Y_out            = y_out_q;
  assign X_out            = x_out_q;
  assign Start_Prediction = start_p_q;
  assign Start_Update     = start_u_q;
  assign m_valid          = m_valid_q;
  assign busy             = busy_q;
  assign timeout_err      = timeout_q;
  assign dbg_state_o      = state_q;

endmodule
